// File: rtl/perceptron_layer_sched_if.sv
// Bundle of the scheduler's write, input, result and core-facing signals.
// The scheduler uses the slave view; the feeder/core environment uses the master view.
interface perceptron_layer_sched_if #(
    parameter int AW = 2
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_err;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic [7:0]    core_weights;
    logic [7:0]    core_inputs;
    logic          core_reset;
    logic [7:0]    core_out;

    modport slave (
        input  wr_en, wr_addr, wr_data, in_valid, in_data, out_ready, core_out,
        output wr_err, in_ready, out_valid, out_data, out_idx, out_last, busy,
               core_weights, core_inputs, core_reset
    );

    modport master (
        output wr_en, wr_addr, wr_data, in_valid, in_data, out_ready, core_out,
        input  wr_err, in_ready, out_valid, out_data, out_idx, out_last, busy,
               core_weights, core_inputs, core_reset
    );
endinterface

// File: rtl/perceptron_layer_sched.sv
// Time-multiplexes one shared 8-input binary-weight perceptron core over NEURONS neurons.
// Optional step activation on captured results is enabled by defining THRESHOLD_ACT_EN.
module perceptron_layer_sched #(
    parameter int NEURONS = 4,
    parameter int AW      = $clog2(NEURONS)
) (
    input logic clk,
    input logic reset_n,
    perceptron_layer_sched_if.slave bus
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_EMIT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    core_weights_q, core_weights_d;
    logic [7:0]    core_inputs_q, core_inputs_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          wr_err_q, wr_err_d;
    logic          core_reset_q;
    logic [7:0]    bank_q [NEURONS];
    logic [7:0]    bank_d [NEURONS];
    logic          addr_bad;
    logic          wr_ok;
    logic          accept;
    logic [7:0]    act_val;

    // Out-of-range addresses only exist when NEURONS is not a power of two.
    generate
        if ((1 << AW) > NEURONS) begin : g_addr_chk
            assign addr_bad = (bus.wr_addr > LAST_IDX);
        end else begin : g_addr_full
            assign addr_bad = 1'b0;
        end
    endgenerate

    assign wr_ok    = bus.wr_en && (state_q == S_IDLE) && !addr_bad;
    assign wr_err_d = bus.wr_en && !wr_ok;
    assign accept   = bus.in_valid && bus.in_ready;

`ifdef THRESHOLD_ACT_EN
    assign act_val = ($signed(bus.core_out) > 8'sd0) ? 8'h01 : 8'h00;
`else
    assign act_val = bus.core_out;
`endif

    always_comb begin
        for (int i = 0; i < NEURONS; i++) begin
            bank_d[i] = bank_q[i];
            if (wr_ok && (bus.wr_addr == AW'(i))) begin
                bank_d[i] = bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        core_weights_d = core_weights_q;
        core_inputs_d  = core_inputs_q;
        out_data_d     = out_data_q;
        out_idx_d      = out_idx_q;
        out_last_d     = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // bank_d so a write on the accept edge is seen by this vector
                    idx_d          = '0;
                    core_weights_d = bank_d[0];
                    core_inputs_d  = bus.in_data;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CAPT;
            S_CAPT: begin
                out_data_d = act_val;
                out_idx_d  = idx_q;
                out_last_d = (idx_q == LAST_IDX);
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d          = idx_q + AW'(1);
                        core_weights_d = bank_q[idx_q + AW'(1)];
                        state_d        = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            core_weights_q <= '0;
            core_inputs_q  <= '0;
            out_data_q     <= '0;
            out_idx_q      <= '0;
            out_last_q     <= 1'b0;
            wr_err_q       <= 1'b0;
            core_reset_q   <= 1'b1;
            for (int i = 0; i < NEURONS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            core_weights_q <= core_weights_d;
            core_inputs_q  <= core_inputs_d;
            out_data_q     <= out_data_d;
            out_idx_q      <= out_idx_d;
            out_last_q     <= out_last_d;
            wr_err_q       <= wr_err_d;
            core_reset_q   <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE) && reset_n;
    assign bus.out_valid    = (state_q == S_EMIT);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.out_data     = out_data_q;
    assign bus.out_idx      = out_idx_q;
    assign bus.out_last     = out_last_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.core_weights = core_weights_q;
    assign bus.core_inputs  = core_inputs_q;
    assign bus.core_reset   = core_reset_q;
endmodule
